// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register slave.
package spi_pkg;

    localparam int SPI_ADDR_W = 7;
    localparam int SPI_DATA_W = 8;

    localparam logic SPI_CMD_RD = 1'b1;
    localparam logic SPI_CMD_WR = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        RD_DATA,
        WR_DATA,
        DRAIN
    } spi_slv_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with single-cycle rise/fall pulses
// derived from the synchronized level.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   prev_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0 <= {SYNC_STAGES{RST_VAL}};
            prev_p1 <= RST_VAL;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], din};
            prev_p1 <= sync_p0[SYNC_STAGES-1];
        end
    end

    assign dout = sync_p0[SYNC_STAGES-1];
    assign rise = dout & ~prev_p1;
    assign fall = ~dout & prev_p1;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 slave turning {rw,addr},{data} frames into register read/write strobes.
// Define SPI_REG_BURST_EN to stream further data bytes with an auto-incremented address.
module spi_reg_slave
    import spi_pkg::*;
#(
    parameter int ADDR_W      = SPI_ADDR_W,
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              cs_n,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_wr_en,
    output logic [DATA_W-1:0] reg_wr_data,
    output logic              reg_rd_en,
    input  logic [DATA_W-1:0] reg_rd_data,
    output logic              busy,
    output logic              frame_err
);

    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    spi_slv_state_t         state, state_nxt;
    logic                   sclk_unused, sclk_rise, sclk_fall;
    logic                   cs_s, cs_rise, cs_fall, mosi_s;
    logic [SYNC_STAGES-1:0] mosi_sync_p0;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_W-2:0]      rx_shift;
    logic [DATA_W-1:0]      rx_byte, tx_shift;
    logic                   in_frame, bit_rise, bit_fall, byte_done;
    logic                   cmd_done, rd_req, wr_req, err_req, rd_load_p1;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (sclk),
        .dout (sclk_unused),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (cs_n),
        .dout (cs_s),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) mosi_sync_p0 <= '0;
        else        mosi_sync_p0 <= {mosi_sync_p0[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_s = mosi_sync_p0[SYNC_STAGES-1];

    // Edges only count inside a live frame; a cs_n rise in the same clk masks them via cs_s.
    assign in_frame  = (state == CMD) || (state == RD_DATA) || (state == WR_DATA);
    assign bit_rise  = sclk_rise && !cs_s && in_frame;
    assign bit_fall  = sclk_fall && !cs_s && (state == RD_DATA);
    assign byte_done = bit_rise && (bit_cnt == LAST_BIT);
    assign rx_byte   = {rx_shift, mosi_s};
    assign busy      = !cs_s;
    assign miso_oe   = !cs_s;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_done  = 1'b0;
        rd_req    = 1'b0;
        wr_req    = 1'b0;
        err_req   = 1'b0;
        case (state)
            IDLE: if (cs_fall) state_nxt = CMD;
            CMD, RD_DATA, WR_DATA: begin
                if (cs_rise) begin
                    state_nxt = IDLE;
                    err_req   = (bit_cnt != '0);
                end else if (byte_done) begin
                    if (state == CMD) begin
                        cmd_done  = 1'b1;
                        rd_req    = (rx_byte[DATA_W-1] == SPI_CMD_RD);
                        state_nxt = (rx_byte[DATA_W-1] == SPI_CMD_WR) ? WR_DATA : RD_DATA;
                    end else begin
                        wr_req = (state == WR_DATA);
`ifdef SPI_REG_BURST_EN
                        rd_req = (state == RD_DATA);
`else
                        state_nxt = DRAIN;
`endif
                    end
                end
            end
            DRAIN:   if (cs_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobe stage: requests become one-clk strobes; read data lands one clk after reg_rd_en.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt     <= '0;
            miso        <= 1'b0;
            reg_addr    <= '0;
            reg_wr_en   <= 1'b0;
            reg_wr_data <= '0;
            reg_rd_en   <= 1'b0;
            rd_load_p1  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            reg_wr_en  <= wr_req;
            reg_rd_en  <= rd_req;
            rd_load_p1 <= reg_rd_en;
            frame_err  <= err_req;
            if (state_nxt == IDLE || state_nxt == DRAIN) bit_cnt <= '0;
            else if (bit_rise)                           bit_cnt <= bit_cnt + CNT_W'(1);
            if (wr_req) reg_wr_data <= rx_byte;
            if (cmd_done) reg_addr <= rx_byte[ADDR_W-1:0];
`ifdef SPI_REG_BURST_EN
            else if (reg_wr_en || (rd_req && state == RD_DATA)) reg_addr <= reg_addr + ADDR_W'(1);
`endif
            if (bit_fall)               miso <= tx_shift[DATA_W-1];
            else if (state != RD_DATA)  miso <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (bit_rise) rx_shift <= rx_byte[DATA_W-2:0];
        if (rd_load_p1)    tx_shift <= reg_rd_data;
        else if (bit_fall) tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
    end

endmodule

// File: tb/tb_spi_reg_slave.sv
// Self-checking bench for spi_reg_slave: SPI master model, register-file model, strobe scoreboard.
module tb_spi_reg_slave;

    localparam int HALF = 5;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk  = 1'b0;
    logic       mosi  = 1'b0;
    logic       cs_n  = 1'b1;
    logic       miso, miso_oe, reg_wr_en, reg_rd_en, busy, frame_err;
    logic [6:0] reg_addr;
    logic [7:0] reg_wr_data, reg_rd_data;

    logic [7:0] mem [128];
    logic       rd_force     = 1'b0;
    logic [7:0] rd_force_val = 8'h00;

    wr_t        exp_wr[$], obs_wr[$];
    logic [6:0] exp_rd[$], obs_rd[$];
    logic [7:0] exp_rx[$];
    int         err_pulses = 0;
    int         checks     = 0;
    int         failures   = 0;

    always #5 clk = ~clk;

    spi_reg_slave dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclk       (sclk),
        .mosi       (mosi),
        .cs_n       (cs_n),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .reg_addr   (reg_addr),
        .reg_wr_en  (reg_wr_en),
        .reg_wr_data(reg_wr_data),
        .reg_rd_en  (reg_rd_en),
        .reg_rd_data(reg_rd_data),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    // Register file: writes land in mem, read data is registered one clk after reg_rd_en.
    always @(posedge clk) begin
        if (reg_wr_en) mem[reg_addr] <= reg_wr_data;
        if (reg_rd_en) reg_rd_data <= rd_force ? rd_force_val : mem[reg_addr];
    end

    always @(negedge clk) begin
        if (reg_wr_en === 1'b1) obs_wr.push_back({reg_addr, reg_wr_data});
        if (reg_rd_en === 1'b1) obs_rd.push_back(reg_addr);
        if (frame_err === 1'b1) err_pulses++;
    end

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            repeat (HALF) @(negedge clk);
            rx[i] = miso;
            sclk  = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk  = 1'b0;
        end
    endtask

    task automatic frame_start;
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic frame_end(input int gap);
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({miso, miso_oe, reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, busy, frame_err} !== 21'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h required 000000",
                     {miso, miso_oe, reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, busy, frame_err});
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write;
        logic [7:0] rx;
        wr_t        e, o;
        int         err0;
        err0 = err_pulses;
        exp_wr.push_back({7'h12, 8'hA5});
        frame_start();
        checks++;
        if ({busy, miso_oe} !== 2'b11) begin
            failures++;
            $display("FAIL busy_in_frame: got busy=%b miso_oe=%b required 1 1", busy, miso_oe);
        end
        xfer(8'h12, 8, rx);
        xfer(8'hA5, 8, rx);
        frame_end(10);
        checks++;
        if (obs_wr.size() != exp_wr.size()) begin
            failures++;
            $display("FAIL write_count: got %0d required %0d", obs_wr.size(), exp_wr.size());
        end
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            e = exp_wr.pop_front();
            o = obs_wr.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL write_strobe: got addr=%h data=%h required addr=%h data=%h", o.addr, o.data, e.addr, e.data);
            end
        end
        exp_wr.delete(); obs_wr.delete();
        checks++;
        if (obs_rd.size() != 0) begin
            failures++;
            $display("FAIL write_no_read: got %0d read strobes required 0", obs_rd.size());
        end
        obs_rd.delete();
        checks++;
        if (err_pulses != err0) begin
            failures++;
            $display("FAIL write_frame_err: got %0d pulses required 0", err_pulses - err0);
        end
    endtask

    task automatic test_read;
        logic [7:0] rx, ex;
        logic [6:0] ea, oa;
        rd_force = 1'b1;
        rd_force_val = 8'h5A;
        exp_rd.push_back(7'h13);
        exp_rx.push_back(8'h5A);
        frame_start();
        xfer(8'h93, 8, rx);
        xfer(8'h00, 8, rx);
        frame_end(10);
        rd_force = 1'b0;
        ex = exp_rx.pop_front();
        checks++;
        if (rx !== ex) begin
            failures++;
            $display("FAIL read_miso: got %h required %h", rx, ex);
        end
        checks++;
        if (obs_rd.size() != exp_rd.size()) begin
            failures++;
            $display("FAIL read_count: got %0d required %0d", obs_rd.size(), exp_rd.size());
        end
        while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
            ea = exp_rd.pop_front();
            oa = obs_rd.pop_front();
            checks++;
            if (oa !== ea) begin
                failures++;
                $display("FAIL read_addr: got %h required %h", oa, ea);
            end
        end
        exp_rd.delete(); obs_rd.delete();
        checks++;
        if (obs_wr.size() != 0) begin
            failures++;
            $display("FAIL read_no_write: got %0d write strobes required 0", obs_wr.size());
        end
        obs_wr.delete();
    endtask

    task automatic test_back_to_back;
        logic [7:0] rx, ex;
        logic [6:0] ea, oa;
        wr_t        e, o;
        exp_wr.push_back({7'h05, 8'hFF});
        exp_rd.push_back(7'h05);
        exp_rx.push_back(8'hFF);
        frame_start();
        xfer(8'h05, 8, rx);
        xfer(8'hFF, 8, rx);
        frame_end(2);
        frame_start();
        xfer(8'h85, 8, rx);
        xfer(8'h00, 8, rx);
        frame_end(10);
        ex = exp_rx.pop_front();
        checks++;
        if (rx !== ex) begin
            failures++;
            $display("FAIL b2b_miso: got %h required %h", rx, ex);
        end
        checks++;
        if (obs_wr.size() != exp_wr.size() || obs_rd.size() != exp_rd.size()) begin
            failures++;
            $display("FAIL b2b_count: got wr=%0d rd=%0d required wr=%0d rd=%0d",
                     obs_wr.size(), obs_rd.size(), exp_wr.size(), exp_rd.size());
        end
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            e = exp_wr.pop_front();
            o = obs_wr.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL b2b_write: got addr=%h data=%h required addr=%h data=%h", o.addr, o.data, e.addr, e.data);
            end
        end
        while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
            ea = exp_rd.pop_front();
            oa = obs_rd.pop_front();
            checks++;
            if (oa !== ea) begin
                failures++;
                $display("FAIL b2b_read_addr: got %h required %h", oa, ea);
            end
        end
        exp_wr.delete(); obs_wr.delete(); exp_rd.delete(); obs_rd.delete();
    endtask

    task automatic test_frame_err;
        logic [7:0] rx;
        wr_t        e, o;
        int         err0;
        err0 = err_pulses;
        frame_start();
        xfer(8'h21, 8, rx);
        xfer(8'hC3, 4, rx);
        frame_end(10);
        checks++;
        if (err_pulses - err0 != 1) begin
            failures++;
            $display("FAIL frame_err_pulse: got %0d cycles required 1", err_pulses - err0);
        end
        checks++;
        if (obs_wr.size() != 0) begin
            failures++;
            $display("FAIL frame_err_no_write: got %0d write strobes required 0", obs_wr.size());
        end
        obs_wr.delete();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL frame_err_busy: got %b required 0", busy);
        end
        exp_wr.push_back({7'h22, 8'h3C});
        frame_start();
        xfer(8'h22, 8, rx);
        xfer(8'h3C, 8, rx);
        frame_end(10);
        checks++;
        if (obs_wr.size() != exp_wr.size()) begin
            failures++;
            $display("FAIL recover_count: got %0d required %0d", obs_wr.size(), exp_wr.size());
        end
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            e = exp_wr.pop_front();
            o = obs_wr.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL recover_write: got addr=%h data=%h required addr=%h data=%h", o.addr, o.data, e.addr, e.data);
            end
        end
        exp_wr.delete(); obs_wr.delete(); obs_rd.delete();
    endtask

    task automatic test_reset_mid;
        logic [7:0] rx;
        int         err0;
        frame_start();
        xfer(8'hA7, 3, rx);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({miso, miso_oe, reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, busy, frame_err} !== 21'h0) begin
            failures++;
            $display("FAIL reset_mid_outputs: got %h required 000000",
                     {miso, miso_oe, reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, busy, frame_err});
        end
        cs_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        err0 = err_pulses;
        for (int i = 0; i < 16; i++) begin
            mosi = 1'($urandom_range(0, 1));
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (10) @(negedge clk);
        checks++;
        if (obs_wr.size() != 0 || obs_rd.size() != 0 || err_pulses != err0) begin
            failures++;
            $display("FAIL idle_sclk_strobes: got wr=%0d rd=%0d err=%0d required 0 0 0",
                     obs_wr.size(), obs_rd.size(), err_pulses - err0);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_busy: got %b required 0", busy);
        end
        obs_wr.delete(); obs_rd.delete();
    endtask

    task automatic test_burst;
        logic [7:0] rx;
        wr_t        e, o;
        exp_wr.push_back({7'h7F, 8'h11});
`ifdef SPI_REG_BURST_EN
        exp_wr.push_back({7'h00, 8'h22});
`endif
        frame_start();
        xfer(8'h7F, 8, rx);
        xfer(8'h11, 8, rx);
        xfer(8'h22, 8, rx);
        frame_end(10);
        checks++;
        if (obs_wr.size() != exp_wr.size()) begin
            failures++;
            $display("FAIL burst_count: got %0d required %0d", obs_wr.size(), exp_wr.size());
        end
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            e = exp_wr.pop_front();
            o = obs_wr.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL burst_write: got addr=%h data=%h required addr=%h data=%h", o.addr, o.data, e.addr, e.data);
            end
        end
        exp_wr.delete(); obs_wr.delete(); obs_rd.delete();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_frame_err();
        test_reset_mid();
        test_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
